// File: rtl/pipe_sched_if.sv
// Bundles the requester, pipe-operand and result-FIFO signals of pipe_sched.
// slave: the scheduler's view; master: the surrounding logic (requesters, pipe, consumer).
// Purely structural: no storage and no latency of its own.
interface pipe_sched_if #(
  parameter int N = 10
);
  logic           r0_valid;
  logic           r0_ready;
  logic [4*N-1:0] r0_op;
  logic           r1_valid;
  logic           r1_ready;
  logic [4*N-1:0] r1_op;
  logic [N-1:0]   p_a;
  logic [N-1:0]   p_b;
  logic [N-1:0]   p_c;
  logic [N-1:0]   p_d;
  logic [N-1:0]   p_f;
  logic           res_valid;
  logic           res_ready;
  logic           res_id;
  logic [N-1:0]   res_data;

  modport slave (
    input  r0_valid, r0_op, r1_valid, r1_op, p_f, res_ready,
    output r0_ready, r1_ready, p_a, p_b, p_c, p_d, res_valid, res_id, res_data
  );

  modport master (
    output r0_valid, r0_op, r1_valid, r1_op, p_f, res_ready,
    input  r0_ready, r1_ready, p_a, p_b, p_c, p_d, res_valid, res_id, res_data
  );
endinterface

// File: rtl/pipe_sched.sv
// Shares a fixed-latency, non-stalling arithmetic pipe between two requesters (round-robin).
// Latency: accept -> operands on p_* next edge; result visible on res_* LAT+1 cycles after accept.
// Backpressure: accepts only while fifo_count + ops in flight < DEPTH, so the FIFO can never overflow.
// Optional PIPE_SCHED_STATS_EN adds per-requester saturating handshake counters (stat_clr/stat0/stat1).
module pipe_sched #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PIPE_SCHED_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat0,
  output logic [15:0] stat1,
`endif
  pipe_sched_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // wide enough for fifo count plus every tag stage being set
  localparam int SW = $clog2(DEPTH + LAT + 2);

  // round-robin preference: requester favoured when both are valid
  logic         prio_q, prio_d;

  // issue register feeding the pipe operands
  logic [N-1:0] p_a_q, p_a_d;
  logic [N-1:0] p_b_q, p_b_d;
  logic [N-1:0] p_c_q, p_c_d;
  logic [N-1:0] p_d_q, p_d_d;

  // tag shift register, stage k tracks the op k cycles after its issue edge
  logic [LAT:0] vld_q, vld_d;
  logic [LAT:0] id_q,  id_d;

  // result FIFO: {id, data} per entry
  logic [N:0]    mem_q [DEPTH];
  logic [N:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [SW-1:0] inflight;
  logic          credit;
  logic          gnt0;
  logic          gnt1;
  logic          hs;
  logic          hs_id;
  logic          push;
  logic          pop;
  logic [N:0]    head;
  logic [4*N-1:0] win_op;

  // credit from registered state only: a pop this cycle frees a slot next cycle
  always_comb begin
    inflight = '0;
    for (int k = 0; k <= LAT; k++) begin
      inflight = inflight + SW'(vld_q[k]);
    end
    credit = (SW'(cnt_q) + inflight) < SW'(DEPTH);
  end

  // grant: lone valid wins, otherwise the preferred requester; never during reset
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && credit) begin
      if (bus.r0_valid && (!bus.r1_valid || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (bus.r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;
  assign hs           = gnt0 | gnt1;
  assign hs_id        = gnt1;
  assign win_op       = gnt1 ? bus.r1_op : bus.r0_op;

  // preference flips to the other requester after every real handshake
  always_comb begin
    prio_d = prio_q;
    if (hs) begin
      prio_d = ~hs_id;
    end
  end

  // operands are loaded on accept and held otherwise
  always_comb begin
    p_a_d = p_a_q;
    p_b_d = p_b_q;
    p_c_d = p_c_q;
    p_d_d = p_d_q;
    if (hs) begin
      p_a_d = win_op[4*N-1:3*N];
      p_b_d = win_op[3*N-1:2*N];
      p_c_d = win_op[2*N-1:N];
      p_d_d = win_op[N-1:0];
    end
  end

  assign bus.p_a = p_a_q;
  assign bus.p_b = p_b_q;
  assign bus.p_c = p_c_q;
  assign bus.p_d = p_d_q;

  // tags advance one stage per clock in lockstep with the pipe
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = hs;
    id_d[0]  = hs_id;
    for (int k = 1; k <= LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k]  = id_q[k-1];
    end
  end

  // last tag stage lines up with a stable p_f: capture it one edge later
  assign push = vld_q[LAT];
  assign pop  = (cnt_q != '0) && bus.res_ready;

  // FIFO pointer/count update; simultaneous push and pop keeps count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {id_q[LAT], bus.p_f};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // head is shown straight from storage; zeroed while empty so idle outputs are clean
  assign head          = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_id    = head[N];
  assign bus.res_data  = head[N-1:0];

  // control state with synchronous reset; in-flight pipe data becomes untagged on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q   <= 1'b0;
      p_a_q    <= '0;
      p_b_q    <= '0;
      p_c_q    <= '0;
      p_d_q    <= '0;
      vld_q    <= '0;
      id_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      prio_q   <= prio_d;
      p_a_q    <= p_a_d;
      p_b_q    <= p_b_d;
      p_c_q    <= p_c_d;
      p_d_q    <= p_d_d;
      vld_q    <= vld_d;
      id_q     <= id_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage needs no reset: it is only observed while count is nonzero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef PIPE_SCHED_STATS_EN
  logic [15:0] stat0_q, stat0_d;
  logic [15:0] stat1_q, stat1_d;

  // saturating handshake counters; clear takes priority over a same-cycle increment
  always_comb begin
    stat0_d = stat0_q;
    stat1_d = stat1_q;
    if (stat_clr) begin
      stat0_d = '0;
      stat1_d = '0;
    end else begin
      if (gnt0 && (stat0_q != 16'hFFFF)) begin
        stat0_d = stat0_q + 16'd1;
      end
      if (gnt1 && (stat1_q != 16'hFFFF)) begin
        stat1_d = stat1_q + 16'd1;
      end
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat0 = stat0_q;
  assign stat1 = stat1_q;
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched with a 3-stage pipe model ((a+b)+(c-d))*d mod 2^N.
// Each scenario task drives stimulus and compares inline; a monitor logs accepts/results.
// Stats scenario is built only when PIPE_SCHED_STATS_EN is defined.
module tb_pipe_sched;
  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic         id;
    logic [N-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ovf = 0;
  ent_t acc_q[$];
  ent_t res_q[$];

  always #10 clk = ~clk;

  pipe_sched_if #(.N(N)) bus();

`ifdef PIPE_SCHED_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat0;
  logic [15:0] stat1;
`endif

  pipe_sched #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PIPE_SCHED_STATS_EN
    .stat_clr (stat_clr),
    .stat0    (stat0),
    .stat1    (stat1),
`endif
    .bus      (bus)
  );

  // pipe model: operands sampled, two internal stages, f stable LAT edges after issue
  logic [N-1:0] s1_sum = '0, s1_dif = '0, s1_d = '0, s2_sum = '0, s2_d = '0, f_q = '0;
  always @(posedge clk) begin
    s1_sum <= bus.p_a + bus.p_b;
    s1_dif <= bus.p_c - bus.p_d;
    s1_d   <= bus.p_d;
    s2_sum <= s1_sum + s1_dif;
    s2_d   <= s1_d;
    f_q    <= s2_sum * s2_d;
  end
  assign bus.p_f = f_q;

  function automatic logic [N-1:0] ref_f(input logic [4*N-1:0] op);
    logic [N-1:0] a, b, c, d, s;
    a = op[4*N-1:3*N];
    b = op[3*N-1:2*N];
    c = op[2*N-1:N];
    d = op[N-1:0];
    s = (a + b) + (c - d);
    return s * d;
  endfunction

  function automatic logic [4*N-1:0] mk_op(input int s);
    return {N'(s * 3 + 1), N'(s + 2), N'(s + 9), N'(s % 5 + 1)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: samples mid-low-phase what the next rising edge will commit
  always @(negedge clk) begin
    ent_t e;
    #5;
    if (bus.r0_valid && bus.r0_ready) begin
      e.id = 1'b0; e.data = ref_f(bus.r0_op); acc_q.push_back(e);
    end
    if (bus.r1_valid && bus.r1_ready) begin
      e.id = 1'b1; e.data = ref_f(bus.r1_op); acc_q.push_back(e);
    end
    if (bus.res_valid && bus.res_ready) begin
      e.id = bus.res_id; e.data = bus.res_data; res_q.push_back(e);
    end
    if (dut.vld_q[LAT] && (dut.cnt_q == DEPTH)) ovf++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    tick();
    rst = 1'b0;
    acc_q.delete();
    res_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && res_q.size() < acc_q.size(); i++) tick();
    checks++;
    if (res_q.size() != acc_q.size()) begin
      errors++;
      $display("FAIL drain: got %0d results, expected %0d", res_q.size(), acc_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.r0_valid = 1'b1;
    bus.r1_valid = 1'b1;
    bus.r0_op = mk_op(1);
    bus.r1_op = mk_op(2);
    bus.res_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {bus.r0_ready, bus.r1_ready});
    end
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res_data} !== '0) begin
      errors++; $display("FAIL reset_res: got v=%b id=%b d=%0d expected 0", bus.res_valid, bus.res_id, bus.res_data);
    end
    checks++;
    if ({bus.p_a, bus.p_b, bus.p_c, bus.p_d} !== '0) begin
      errors++; $display("FAIL reset_pipe_ops: got %h expected 0", {bus.p_a, bus.p_b, bus.p_c, bus.p_d});
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [4*N-1:0] op;
    int e0;
    do_reset();
    bus.res_ready = 1'b1;
    op = {10'd1, 10'd2, 10'd5, 10'd3};
    bus.r0_op = op;
    bus.r0_valid = 1'b1;
    #1;
    checks++;
    if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      errors++; $display("FAIL t1_ready: got %b expected 10", {bus.r0_ready, bus.r1_ready});
    end
    tick();
    bus.r0_valid = 1'b0;
    e0 = cyc;
    checks++;
    if ({bus.p_a, bus.p_b, bus.p_c, bus.p_d} !== op) begin
      errors++; $display("FAIL t1_operands: got %h expected %h", {bus.p_a, bus.p_b, bus.p_c, bus.p_d}, op);
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL t1_early_valid: got %b at +%0d expected 0", bus.res_valid, cyc - e0);
    end
    tick();
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res_data} !== {1'b1, 1'b0, 10'd15}) begin
      errors++; $display("FAIL t1_result: got v=%b id=%b d=%0d expected v=1 id=0 d=15", bus.res_valid, bus.res_id, bus.res_data);
    end
    tick();
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL t1_popped: got res_valid=%b expected 0", bus.res_valid);
    end
  endtask

  task automatic test_alternate();
    int g[$];
    int s0, s1, both;
    bit t0, t1;
    do_reset();
    bus.res_ready = 1'b1;
    s0 = 10; s1 = 50; both = 0;
    bus.r0_op = mk_op(s0);
    bus.r1_op = mk_op(s1);
    bus.r0_valid = 1'b1;
    bus.r1_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      t0 = bus.r0_ready;
      t1 = bus.r1_ready;
      if (t0 && t1) both++;
      if (t0) g.push_back(0);
      else if (t1) g.push_back(1);
      tick();
      if (t0) begin s0++; bus.r0_op = mk_op(s0); end
      if (t1) begin s1++; bus.r1_op = mk_op(s1); end
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    drain();
    checks++;
    if (both != 0) begin
      errors++; $display("FAIL t2_one_ready: got %0d cycles with both ready, expected 0", both);
    end
    checks++;
    if (g.size() < 8) begin
      errors++; $display("FAIL t2_grant_count: got %0d grants expected >= 8", g.size());
    end
    for (int i = 0; i < g.size(); i++) begin
      checks++;
      if (g[i] != (i % 2)) begin
        errors++; $display("FAIL t2_grant_order: grant %0d got r%0d expected r%0d", i, g[i], i % 2);
      end
    end
    for (int i = 0; i < res_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (res_q[i] !== acc_q[i]) begin
        errors++; $display("FAIL t2_result: idx %0d got id=%b d=%0d expected id=%b d=%0d",
                           i, res_q[i].id, res_q[i].data, acc_q[i].id, acc_q[i].data);
      end
    end
  endtask

  task automatic test_credit();
    int n1, n2, s;
    bit t0;
    do_reset();
    bus.res_ready = 1'b0;
    s = 100; n1 = 0; n2 = 0;
    bus.r0_op = mk_op(s);
    bus.r0_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      t0 = bus.r0_ready;
      if (t0) n1++;
      tick();
      if (t0) begin s++; bus.r0_op = mk_op(s); end
    end
    #1;
    checks++;
    if (n1 != DEPTH) begin
      errors++; $display("FAIL t3_accepts_full: got %0d expected %0d", n1, DEPTH);
    end
    checks++;
    if ({bus.r0_ready, bus.res_valid} !== 2'b01) begin
      errors++; $display("FAIL t3_blocked: got ready/res_valid=%b expected 01", {bus.r0_ready, bus.res_valid});
    end
    bus.res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      t0 = bus.r0_ready;
      if (t0) n2++;
      tick();
      if (t0) begin s++; bus.r0_op = mk_op(s); end
    end
    bus.r0_valid = 1'b0;
    drain();
    checks++;
    if (n2 == 0 || res_q.size() != n1 + n2) begin
      errors++; $display("FAIL t3_resume: got %0d later accepts, %0d results, expected >0 and %0d", n2, res_q.size(), n1 + n2);
    end
    for (int i = 0; i < res_q.size() && i < acc_q.size(); i++) begin
      checks++;
      if (res_q[i] !== acc_q[i]) begin
        errors++; $display("FAIL t3_result: idx %0d got d=%0d expected d=%0d", i, res_q[i].data, acc_q[i].data);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.res_ready = 1'b1;
    bus.r0_op = {10'd1023, 10'd1, 10'd0, 10'd0};
    bus.r0_valid = 1'b1;
    tick();
    bus.r0_op = {10'd600, 10'd0, 10'd2, 10'd2};
    tick();
    bus.r0_valid = 1'b0;
    drain();
    checks++;
    if (res_q.size() != 2) begin
      errors++; $display("FAIL t4_count: got %0d expected 2", res_q.size());
    end else begin
      checks++;
      if (res_q[0].data !== 10'd0) begin
        errors++; $display("FAIL t4_wrap_sum: got %0d expected 0", res_q[0].data);
      end
      checks++;
      if (res_q[1].data !== 10'd176) begin
        errors++; $display("FAIL t4_wrap_mul: got %0d expected 176", res_q[1].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int lat;
    do_reset();
    bus.res_ready = 1'b1;
    bus.r0_op = mk_op(3);
    bus.r0_valid = 1'b1;
    tick();
    bus.r0_op = mk_op(4);
    tick();
    bus.r0_valid = 1'b0;
    tick();
    checks++;
    if (acc_q.size() != 2) begin
      errors++; $display("FAIL t5_accepts: got %0d expected 2", acc_q.size());
    end
    rst = 1'b1;
    bus.r0_valid = 1'b1;
    #1;
    checks++;
    if (bus.r0_ready !== 1'b0) begin
      errors++; $display("FAIL t5_ready_in_rst: got %b expected 0", bus.r0_ready);
    end
    tick();
    rst = 1'b0;
    bus.r0_valid = 1'b0;
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res_data, bus.p_a, bus.p_b, bus.p_c, bus.p_d} !== '0) begin
      errors++; $display("FAIL t5_reset_outputs: got v=%b d=%0d ops=%h expected 0", bus.res_valid, bus.res_data,
                         {bus.p_a, bus.p_b, bus.p_c, bus.p_d});
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.res_valid) seen = 1'b1;
    end
    checks++;
    if (seen || res_q.size() != 0) begin
      errors++; $display("FAIL t5_discard: got res_valid seen=%b results=%0d expected 0/0", seen, res_q.size());
    end
    bus.r0_op = {10'd1, 10'd2, 10'd5, 10'd3};
    bus.r0_valid = 1'b1;
    tick();
    bus.r0_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (bus.res_valid) lat = i;
    end
    checks++;
    if (lat != 4 || bus.res_data !== 10'd15) begin
      errors++; $display("FAIL t5_after_reset: got latency %0d data %0d expected 4 and 15", lat, bus.res_data);
    end
    tick();
  endtask

`ifdef PIPE_SCHED_STATS_EN
  task automatic test_stats();
    int n;
    do_reset();
    bus.res_ready = 1'b1;
    n = 0;
    bus.r0_op = mk_op(7);
    bus.r0_valid = 1'b1;
    for (int i = 0; i < 40 && n < 5; i++) begin
      #1; if (bus.r0_ready) n++;
      tick();
    end
    bus.r0_valid = 1'b0;
    n = 0;
    bus.r1_op = mk_op(8);
    bus.r1_valid = 1'b1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      #1; if (bus.r1_ready) n++;
      tick();
    end
    bus.r1_valid = 1'b0;
    checks++;
    if (stat0 !== 16'd5 || stat1 !== 16'd3) begin
      errors++; $display("FAIL t6_counts: got %0d/%0d expected 5/3", stat0, stat1);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (stat0 !== 16'd0 || stat1 !== 16'd0) begin
      errors++; $display("FAIL t6_clear: got %0d/%0d expected 0/0", stat0, stat1);
    end
    drain();
    force dut.stat0_q = 16'hFFFF;
    tick();
    release dut.stat0_q;
    bus.r0_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 1; i++) begin
      #1; if (bus.r0_ready) n++;
      tick();
    end
    bus.r0_valid = 1'b0;
    checks++;
    if (n != 1 || stat0 !== 16'hFFFF) begin
      errors++; $display("FAIL t6_saturate: got grants=%0d stat0=%h expected 1 and FFFF", n, stat0);
    end
    drain();
  endtask
`endif

  task automatic test_no_overflow();
    checks++;
    if (ovf != 0) begin
      errors++; $display("FAIL fifo_overflow: got %0d pushes into a full FIFO, expected 0", ovf);
    end
  endtask

  initial begin
    bus.r0_valid  = 1'b0;
    bus.r1_valid  = 1'b0;
    bus.r0_op     = '0;
    bus.r1_op     = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_credit();
    test_wrap();
    test_reset_mid();
`ifdef PIPE_SCHED_STATS_EN
    test_stats();
`endif
    test_no_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
